// File: rtl/universal_shift_register_param.sv
// Parametrised universal shift register with rotate, arithmetic shift and burst mode.
// Optional parity output enabled by defining USR_PARITY_OUT_EN.
module universal_shift_register_param #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 4
) (
   input  logic                   Clk_In,
   input  logic                   Reset_In,
   input  logic                   Enable_In,
   input  logic [2:0]             Operation_Select_In,
   input  logic [COUNT_WIDTH-1:0] Shift_Count_In,
   input  logic                   Burst_Direction_In,
   input  logic                   Serial_Left_Side_Data_In,
   input  logic                   Serial_Right_Side_Data_In,
   input  logic [DATA_WIDTH-1:0]  Parallel_Data_In,
   output logic                   Serial_Left_Side_Data_Out,
   output logic                   Serial_Right_Side_Data_Out,
   output logic [DATA_WIDTH-1:0]  Parallel_Data_Out,
   output logic                   Busy_Out,
   output logic                   Done_Out
`ifdef USR_PARITY_OUT_EN
   ,
   output logic                   Parity_Out
`endif
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_BUSY = 1'b1;

   localparam logic [2:0] OP_SHL   = 3'd1;
   localparam logic [2:0] OP_SHR   = 3'd2;
   localparam logic [2:0] OP_LOAD  = 3'd3;
   localparam logic [2:0] OP_ROL   = 3'd4;
   localparam logic [2:0] OP_ROR   = 3'd5;
   localparam logic [2:0] OP_ASR   = 3'd6;
   localparam logic [2:0] OP_BURST = 3'd7;

   logic [DATA_WIDTH-1:0]  reg_q, reg_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   dir_q, dir_d;
   logic                   state_q, state_d;
   logic                   done_q, done_d;

   always_comb begin
      reg_d   = reg_q;
      count_d = count_q;
      dir_d   = dir_q;
      state_d = state_q;
      done_d  = 1'b0;
      if (Enable_In) begin
         if (state_q == ST_BUSY) begin
            // Burst shifts take the live serial input of the entering side
            if (dir_q)
               reg_d = {Serial_Left_Side_Data_In, reg_q[DATA_WIDTH-1:1]};
            else
               reg_d = {reg_q[DATA_WIDTH-2:0], Serial_Right_Side_Data_In};
            count_d = count_q - COUNT_WIDTH'(1);
            if (count_q == COUNT_WIDTH'(1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end else begin
            case (Operation_Select_In)
               OP_SHL:
                  reg_d = {reg_q[DATA_WIDTH-2:0], Serial_Right_Side_Data_In};
               OP_SHR:
                  reg_d = {Serial_Left_Side_Data_In, reg_q[DATA_WIDTH-1:1]};
               OP_LOAD:
                  reg_d = Parallel_Data_In;
               OP_ROL:
                  reg_d = {reg_q[DATA_WIDTH-2:0], reg_q[DATA_WIDTH-1]};
               OP_ROR:
                  reg_d = {reg_q[0], reg_q[DATA_WIDTH-1:1]};
               OP_ASR:
                  reg_d = {reg_q[DATA_WIDTH-1], reg_q[DATA_WIDTH-1:1]};
               OP_BURST: begin
                  count_d = Shift_Count_In;
                  dir_d   = Burst_Direction_In;
                  if (Shift_Count_In == '0)
                     done_d = 1'b1;
                  else
                     state_d = ST_BUSY;
               end
               default:
                  reg_d = reg_q;
            endcase
         end
      end
   end

   always_ff @(negedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         reg_q   <= '0;
         count_q <= '0;
         dir_q   <= 1'b0;
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
      end else begin
         reg_q   <= reg_d;
         count_q <= count_d;
         dir_q   <= dir_d;
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   assign Parallel_Data_Out          = reg_q;
   assign Serial_Left_Side_Data_Out  = reg_q[DATA_WIDTH-1];
   assign Serial_Right_Side_Data_Out = reg_q[0];
   assign Busy_Out                   = (state_q == ST_BUSY);
   assign Done_Out                   = done_q;

`ifdef USR_PARITY_OUT_EN
   assign Parity_Out = ^reg_q;
`endif

endmodule
